// File: rtl/mac_tx_fcs_insert_if.sv
// AXI-Stream beat bundle shared by the FCS inserter's upstream and downstream sides.
interface mac_tx_fcs_insert_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned KeepWidth = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KeepWidth-1:0]  tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mac_tx_fcs_insert.sv
// TX MAC stage: tracks the running CRC-32 through an external slicing-by-4 engine and
// appends the 4-byte FCS after the last payload byte, costing one extra beat per frame.
module mac_tx_fcs_insert #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mac_tx_fcs_insert_if.slave    s_axis,
    mac_tx_fcs_insert_if.master   m_axis,
    output logic [DATA_WIDTH-1:0] o_crc_data,
    output logic [KEEP_WIDTH-1:0] o_crc_data_valid,
    output logic [31:0]           o_crc_state,
    input  logic [31:0]           i_crc_state_next
);

    typedef enum logic [0:0] {StData, StTail} state_e;

    state_e      state_q;
    logic [31:0] crc_q;
    logic [31:0] tail_data_q;
    logic [3:0]  tail_keep_q;
    logic [31:0] out_data_q;
    logic [3:0]  out_keep_q;
    logic        out_valid_q;
    logic        out_last_q;

    logic        free;
    logic        accept;
    logic [2:0]  n_bytes;
    logic [31:0] fcs;
    logic [31:0] byte_mask;
    logic [63:0] packed_beat;
    logic [3:0]  last_keep;

    assign free   = !out_valid_q || m_axis.tready;
    assign accept = (state_q == StData) && free && s_axis.tvalid;

    assign s_axis.tready    = (state_q == StData) && free;
    assign m_axis.tdata     = out_data_q;
    assign m_axis.tkeep     = out_keep_q;
    assign m_axis.tvalid    = out_valid_q;
    assign m_axis.tlast     = out_last_q;
    assign o_crc_data       = s_axis.tdata;
    assign o_crc_data_valid = s_axis.tkeep;
    assign o_crc_state      = crc_q;

    // Payload bytes, then FCS bytes LSB first; upper word becomes the tail beat.
    always_comb begin
        n_bytes   = 3'd4;
        byte_mask = '0;
        case (s_axis.tkeep)
            4'b0001: n_bytes = 3'd1;
            4'b0011: n_bytes = 3'd2;
            4'b0111: n_bytes = 3'd3;
            default: n_bytes = 3'd4;
        endcase
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{s_axis.tkeep[i]}};
        end
        fcs         = ~i_crc_state_next;
        packed_beat = {32'h0, s_axis.tdata & byte_mask} | ({32'h0, fcs} << {n_bytes, 3'b000});
        last_keep   = 4'b1111 >> (3'd4 - n_bytes);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StData;
            crc_q       <= CRC_INIT;
            tail_data_q <= '0;
            tail_keep_q <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StData: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        out_keep_q  <= 4'b1111;
                        out_last_q  <= 1'b0;
                        if (s_axis.tlast) begin
                            out_data_q  <= packed_beat[31:0];
                            tail_data_q <= packed_beat[63:32];
                            tail_keep_q <= last_keep;
                            crc_q       <= CRC_INIT;
                            state_q     <= StTail;
                        end else begin
                            out_data_q <= s_axis.tdata;
                            crc_q      <= i_crc_state_next;
                        end
                    end else if (free) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StTail: begin
                    if (free) begin
                        out_data_q  <= tail_data_q;
                        out_keep_q  <= tail_keep_q;
                        out_last_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StData;
                    end
                end
                default: state_q <= StData;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
// Bench for mac_tx_fcs_insert: table of known-CRC frames, stall/back-to-back/reset
// sequences and random frames, all scored against expected beats queued at drive time.
module tb_mac_tx_fcs_insert;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;
    typedef struct {
        string       payload;
        logic [31:0] fcs;
        int          stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] crc_data;
    logic [3:0]  crc_valid;
    logic [31:0] crc_state;
    logic [31:0] crc_next;

    mac_tx_fcs_insert_if #(.DATA_WIDTH(32)) s_axis ();
    mac_tx_fcs_insert_if #(.DATA_WIDTH(32)) m_axis ();

    mac_tx_fcs_insert #(
        .DATA_WIDTH(32),
        .KEEP_WIDTH(4),
        .CRC_INIT  (32'hFFFF_FFFF)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .s_axis          (s_axis),
        .m_axis          (m_axis),
        .o_crc_data      (crc_data),
        .o_crc_data_valid(crc_valid),
        .o_crc_state     (crc_state),
        .i_crc_state_next(crc_next)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    int    stall_mode = 0;
    int    rdy_cnt = 0;
    int    bubbles = 0;
    int    beat_no = 0;
    logic  prev_stall = 1'b0;
    logic [37:0] held;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] sw_fcs(input bytes_t pl);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (pl[i]) c = crc_byte(c, pl[i]);
        return ~c;
    endfunction

    // External CRC engine model.
    always_comb begin
        crc_next = crc_state;
        for (int i = 0; i < 4; i++) begin
            if (crc_valid[i]) crc_next = crc_byte(crc_next, crc_data[8*i +: 8]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic die(input string what);
        errors++;
        checks++;
        $display("FAIL %s: no response within bound", what);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench aborted");
    endtask

    // Downstream ready pattern.
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            if (stall_mode == 0) m_axis.tready = 1'b1;
            else if (stall_mode < 0) m_axis.tready = ($urandom_range(0, 3) != 0);
            else m_axis.tready = ((rdy_cnt % (stall_mode + 1)) == 0);
        end
    end

    // Output monitor: scoreboard pop, hold-while-stalled check, bubble count, input rules.
    always @(negedge clk) begin
        if (prev_stall && !reset) begin
            check("hold", {26'h0, m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast},
                  {26'h0, held});
        end
        if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {27'h0, m_axis.tdata, m_axis.tkeep, m_axis.tlast}, 64'h0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check($sformatf("beat%0d", beat_no), {27'h0, m_axis.tdata, m_axis.tkeep,
                      m_axis.tlast}, {27'h0, e.data, e.keep, e.last});
                beat_no++;
            end
        end
        prev_stall = !reset && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b0;
        held = {m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast};
        if (s_axis.tready === 1'b0) bubbles++;
        if (s_axis.tvalid === 1'b1 && s_axis.tlast === 1'b0)
            assert (s_axis.tkeep == 4'hF) else $error("non-last beat with partial tkeep");
        if (s_axis.tvalid === 1'b1 && s_axis.tlast === 1'b1)
            assert (s_axis.tkeep inside {4'h1, 4'h3, 4'h7, 4'hF}) else $error("bad last tkeep");
    end

    task automatic expect_frame(input bytes_t pl, input logic [31:0] fcs);
        bytes_t st;
        st = pl;
        for (int i = 0; i < 4; i++) st.push_back(fcs[8*i +: 8]);
        for (int b = 0; b < st.size(); b += 4) begin
            beat_t e;
            e = '0;
            for (int j = 0; j < 4; j++) begin
                if (b + j < st.size()) begin
                    e.data[8*j +: 8] = st[b + j];
                    e.keep[j] = 1'b1;
                end
            end
            e.last = (b + 4 >= st.size());
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis.tready === 1'b1) break;
            t++;
            if (t > 2000) die("s_axis_accept");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input bytes_t pl);
        for (int b = 0; b < pl.size(); b += 4) begin
            logic [31:0] d;
            logic [3:0]  k;
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (b + j < pl.size()) begin
                    d[8*j +: 8] = pl[b + j];
                    k[j] = 1'b1;
                end
            end
            drive_beat(d, k, b + 4 >= pl.size());
        end
    endtask

    task automatic idle();
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            t++;
            if (t > 20000) die("m_axis_drain");
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bytes_t str_bytes(input string s);
        bytes_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s.getc(i));
        return q;
    endfunction

    initial begin
        vec_t   vecs[5];
        bytes_t f1;
        bytes_t pl;

        vecs[0] = '{"123456789", 32'hCBF4_3926, 0};
        vecs[1] = '{"1234", 32'h9BE3_E0A3, 0};
        vecs[2] = '{"123456789", 32'hCBF4_3926, 3};
        vecs[3] = '{"a", 32'hE8B7_BE43, 0};
        vecs[4] = '{"The quick brown fox jumps over the lazy dog", 32'h414F_A339, 2};

        reset = 1'b1;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_tvalid", {63'h0, m_axis.tvalid}, 64'h0);
        check("reset_tdata_keep_last", {27'h0, m_axis.tdata, m_axis.tkeep, m_axis.tlast}, 64'h0);
        check("reset_crc_state", {32'h0, crc_state}, {32'h0, 32'hFFFF_FFFF});
        check("reset_s_tready", {63'h0, s_axis.tready}, 64'h1);

        foreach (vecs[i]) begin
            stall_mode = vecs[i].stall;
            pl = str_bytes(vecs[i].payload);
            expect_frame(pl, vecs[i].fcs);
            drive_frame(pl);
            idle();
            wait_drain();
        end
        stall_mode = 0;
        @(posedge clk);
        #1;

        // Back-to-back frames: only the two TAIL cycles may deassert s_axis_tready.
        f1 = str_bytes("123456789");
        expect_frame(f1, 32'hCBF4_3926);
        expect_frame(f1, 32'hCBF4_3926);
        bubbles = 0;
        drive_frame(f1);
        drive_frame(f1);
        idle();
        wait_drain();
        check("b2b_tready_low_cycles", 64'(bubbles), 64'd2);

        // Reset during beat 2: only beat 1 leaves, then a clean resend.
        exp_q.push_back('{32'h3433_3231, 4'hF, 1'b0});
        drive_beat(32'h3433_3231, 4'hF, 1'b0);
        s_axis.tdata  = 32'h3837_3635;
        s_axis.tkeep  = 4'hF;
        s_axis.tvalid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        check("midreset_tvalid", {63'h0, m_axis.tvalid}, 64'h0);
        check("midreset_crc_state", {32'h0, crc_state}, {32'h0, 32'hFFFF_FFFF});
        check("midreset_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        expect_frame(f1, 32'hCBF4_3926);
        drive_frame(f1);
        idle();
        wait_drain();

        // Random lengths against the software CRC model, random downstream stalls.
        stall_mode = -1;
        for (int n = 0; n < 6; n++) begin
            int len;
            len = (n == 0) ? 1518 : (n == 1) ? 2 : $urandom_range(1, 1518);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            expect_frame(pl, sw_fcs(pl));
            drive_frame(pl);
        end
        idle();
        wait_drain();
        stall_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_tvalid", {63'h0, m_axis.tvalid}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
